// File: rtl/axis_frame_source_pkg.sv
// Shared constants, read-side state encoding and T_USER field layout for the
// AXI-Stream frame source.
package axis_frame_source_pkg;

   localparam int DFLT_DATA_WIDTH = 32;
   localparam int DFLT_FRAME_LEN  = 64;
   localparam int DFLT_ADDR_WIDTH = 6;

   localparam int USER_FIELD_W = 8;
   localparam int USER_IDX_LSB = 0;
   localparam int USER_FRM_LSB = 8;

   typedef enum logic [1:0] {
      RD_IDLE,
      RD_PRIME,
      RD_STREAM
   } rd_state_t;

endpackage

// File: rtl/axis_frame_source_pingpong_ram.sv
// Simple dual-port sample store holding both ping-pong banks; address = {bank, index},
// synchronous read.
module pingpong_ram
   import axis_frame_source_pkg::*;
#(
   parameter int DATA_WIDTH = DFLT_DATA_WIDTH,
   parameter int ADDR_WIDTH = DFLT_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH:0]   waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [ADDR_WIDTH:0]   raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [0:(2 << ADDR_WIDTH) - 1];

   always_ff @(posedge clk) begin
      if (we)
         mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/axis_frame_source.sv
// Packs free-running samples into fixed-length frames through a ping-pong buffer
// and streams them out as an AXI-Stream master with frame/beat tagging.
module axis_frame_source
   import axis_frame_source_pkg::*;
#(
   parameter int DATA_WIDTH = DFLT_DATA_WIDTH,
   parameter int FRAME_LEN  = DFLT_FRAME_LEN,
   parameter int ADDR_WIDTH = DFLT_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] S_DATA,
   input  logic                  S_WE,
   output logic [DATA_WIDTH-1:0] T_DATA,
   output logic                  T_VALID,
   input  logic                  T_READY,
   output logic                  T_LAST,
   output logic [15:0]           T_USER,
   output logic                  Overflow,
   output logic                  Frame_Sent
);

   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(FRAME_LEN - 1);

   logic [1:0]            full, full_set, full_clr;
   logic                  wr_bank, rd_bank;
   logic [ADDR_WIDTH-1:0] wr_idx, rd_idx;
   logic [7:0]            frame_cnt;
   rd_state_t             state;
   logic                  t_valid_r;
   logic                  hs, rd_last, wr_last, release_bank, wr_ok;
   logic [ADDR_WIDTH:0]   wr_addr, rd_addr;

   assign hs           = t_valid_r && T_READY;
   assign rd_last      = (rd_idx == LAST_IDX);
   assign wr_last      = (wr_idx == LAST_IDX);
   assign release_bank = hs && rd_last;
   // A bank being released this cycle can already take the next sample.
   assign wr_ok        = S_WE && (!full[wr_bank] || (release_bank && (rd_bank == wr_bank)));
   assign wr_addr      = {wr_bank, wr_idx};

   always_comb begin
      full_set = '0;
      full_clr = '0;
      if (wr_ok && wr_last)
         full_set[wr_bank] = 1'b1;
      if (release_bank)
         full_clr[rd_bank] = 1'b1;
   end

   // Look one beat ahead so the synchronous RAM keeps up with one beat per cycle.
   always_comb begin
      if (release_bank)
         rd_addr = {~rd_bank, {ADDR_WIDTH{1'b0}}};
      else if (hs)
         rd_addr = {rd_bank, rd_idx + 1'b1};
      else
         rd_addr = {rd_bank, rd_idx};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         full     <= '0;
         wr_bank  <= 1'b0;
         wr_idx   <= '0;
         Overflow <= 1'b0;
      end else begin
         full     <= (full & ~full_clr) | full_set;
         Overflow <= S_WE && !wr_ok;
         if (wr_ok) begin
            if (wr_last) begin
               wr_idx  <= '0;
               wr_bank <= ~wr_bank;
            end else begin
               wr_idx <= wr_idx + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= RD_IDLE;
         rd_bank    <= 1'b0;
         rd_idx     <= '0;
         frame_cnt  <= '0;
         t_valid_r  <= 1'b0;
         Frame_Sent <= 1'b0;
      end else begin
         Frame_Sent <= release_bank;
         case (state)
            RD_IDLE: begin
               if (full[rd_bank])
                  state <= RD_PRIME;
            end
            RD_PRIME: begin
               state     <= RD_STREAM;
               t_valid_r <= 1'b1;
            end
            RD_STREAM: begin
               if (hs) begin
                  if (rd_last) begin
                     rd_idx    <= '0;
                     rd_bank   <= ~rd_bank;
                     frame_cnt <= frame_cnt + 1'b1;
                     // The next bank's word 0 is already addressed, so no bubble is needed.
                     if (!full[~rd_bank]) begin
                        state     <= RD_IDLE;
                        t_valid_r <= 1'b0;
                     end
                  end else begin
                     rd_idx <= rd_idx + 1'b1;
                  end
               end
            end
            default: begin
               state     <= RD_IDLE;
               t_valid_r <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      T_USER = '0;
      T_USER[USER_FRM_LSB +: USER_FIELD_W] = frame_cnt;
      T_USER[USER_IDX_LSB +: USER_FIELD_W] = USER_FIELD_W'(rd_idx);
   end

   assign T_VALID = t_valid_r;
   assign T_LAST  = t_valid_r && rd_last;

   pingpong_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk   (clk),
      .we    (wr_ok),
      .waddr (wr_addr),
      .wdata (S_DATA),
      .raddr (rd_addr),
      .rdata (T_DATA)
   );

endmodule

// File: tb/tb_axis_frame_source.sv
// Scoreboard bench for axis_frame_source: writes push expected beats, a negedge
// monitor pops and compares every handshake.
module tb_axis_frame_source;

   typedef struct packed {
      logic [31:0] d;
      logic [15:0] u;
      logic        l;
   } beat_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] S_DATA;
   logic        S_WE;
   logic [31:0] T_DATA;
   logic        T_VALID;
   logic        T_READY = 1'b0;
   logic        T_LAST;
   logic [15:0] T_USER;
   logic        Overflow;
   logic        Frame_Sent;

   beat_t q[$];
   int    errors = 0;
   int    checks = 0;
   int    wcount = 0;
   int    ovf_seen = 0;
   int    fs_seen = 0;
   int    rdy_mode = 0;
   bit    prev_stall = 1'b0;
   beat_t held;

   axis_frame_source dut (
      .clk        (clk),
      .reset      (reset),
      .S_DATA     (S_DATA),
      .S_WE       (S_WE),
      .T_DATA     (T_DATA),
      .T_VALID    (T_VALID),
      .T_READY    (T_READY),
      .T_LAST     (T_LAST),
      .T_USER     (T_USER),
      .Overflow   (Overflow),
      .Frame_Sent (Frame_Sent)
   );

   always #5 clk = ~clk;

   // Ready pattern: 0 = held low, 1 = held high, 2 = pseudo-random.
   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0:       T_READY = 1'b0;
         1:       T_READY = 1'b1;
         default: T_READY = 1'($urandom_range(0, 1));
      endcase
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   always @(negedge clk) begin
      beat_t got;
      beat_t exp;
      if (reset !== 1'b1) begin
         got = {T_DATA, T_USER, T_LAST};
         if (prev_stall)
            check("stall_hold", {15'b0, T_VALID, got}, {15'b0, 1'b1, held});
         if (T_VALID && T_READY) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_beat: got data %0h user %0h with no beat expected", T_DATA, T_USER);
            end else begin
               exp = q.pop_front();
               check("beat", 64'(got), 64'(exp));
            end
         end
         prev_stall = T_VALID && !T_READY;
         held       = got;
         if (Overflow)   ovf_seen++;
         if (Frame_Sent) fs_seen++;
      end
   end

   task automatic push_exp(input logic [31:0] d);
      beat_t b;
      b.d = d;
      b.u = {8'(wcount / 64), 8'(wcount % 64)};
      b.l = ((wcount % 64) == 63);
      q.push_back(b);
      wcount++;
   endtask

   task automatic wr(input logic [31:0] d, input bit accept);
      S_WE   = 1'b1;
      S_DATA = d;
      if (accept)
         push_exp(d);
      @(posedge clk);
      #1;
      S_WE = 1'b0;
   endtask

   task automatic set_rdy(input int m);
      @(negedge clk);
      rdy_mode = m;
      @(posedge clk);
      #2;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (q.size() != 0 && n < 2000) begin
         @(posedge clk);
         n++;
      end
      check(name, 64'(q.size()), 64'd0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      int base_fs, base_ovf, nhs, n;
      reset  = 1'b1;
      S_WE   = 1'b0;
      S_DATA = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", 64'(T_VALID), 64'd0);
      check("rst_last", 64'(T_LAST), 64'd0);
      check("rst_user", 64'(T_USER), 64'd0);
      check("rst_overflow", 64'(Overflow), 64'd0);
      check("rst_frame_sent", 64'(Frame_Sent), 64'd0);
      reset = 1'b0;

      // Basic frame with ready held high
      set_rdy(1);
      base_fs = fs_seen;
      for (int i = 0; i < 64; i++) wr(32'(i), 1'b1);
      check("lat_after_write", 64'(T_VALID), 64'd0);
      @(posedge clk); #1;
      check("lat_prime", 64'(T_VALID), 64'd0);
      @(posedge clk); #1;
      check("lat_stream", 64'(T_VALID), 64'd1);
      drain("basic_drain");
      check("basic_frame_sent", 64'(fs_seen - base_fs), 64'd1);

      // Random backpressure over two frames
      set_rdy(2);
      base_fs  = fs_seen;
      base_ovf = ovf_seen;
      for (int i = 0; i < 128; i++) wr(32'hA500_0000 + 32'(i), 1'b1);
      drain("bp_drain");
      check("bp_frame_sent", 64'(fs_seen - base_fs), 64'd2);
      check("bp_overflow", 64'(ovf_seen - base_ovf), 64'd0);

      // Both banks full, then release: 128 contiguous beats
      set_rdy(0);
      base_fs = fs_seen;
      for (int i = 0; i < 128; i++) wr(32'h3000_0000 + 32'(i), 1'b1);
      check("b2b_valid_stalled", 64'(T_VALID), 64'd1);
      set_rdy(1);
      nhs = 0;
      repeat (128) begin
         @(negedge clk);
         if (T_VALID && T_READY) nhs++;
      end
      check("b2b_contiguous", 64'(nhs), 64'd128);
      drain("b2b_drain");
      check("b2b_frame_sent", 64'(fs_seen - base_fs), 64'd2);

      // Overflow with both banks full, then next sample lands at index 0
      set_rdy(0);
      for (int i = 0; i < 128; i++) wr(32'h4000_0000 + 32'(i), 1'b1);
      base_ovf = ovf_seen;
      base_fs  = fs_seen;
      for (int i = 0; i < 5; i++) wr(32'hDEAD_0000 + 32'(i), 1'b0);
      repeat (2) @(posedge clk);
      #1;
      check("ovf_pulses", 64'(ovf_seen - base_ovf), 64'd5);
      set_rdy(1);
      n = 0;
      while (fs_seen == base_fs && n < 300) begin
         @(posedge clk); #2;
         n++;
      end
      check("ovf_release_seen", 64'(fs_seen - base_fs), 64'd1);
      for (int i = 0; i < 64; i++) wr(32'h4444_0000 + 32'(i), 1'b1);
      drain("ovf_drain");

      // Sample written in the same cycle its bank is released
      set_rdy(0);
      for (int i = 0; i < 128; i++) wr(32'h5000_0000 + 32'(i), 1'b1);
      base_ovf = ovf_seen;
      set_rdy(1);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(T_VALID && T_READY && T_LAST) && n < 300);
      check("coll_last_seen", 64'(T_VALID && T_READY && T_LAST), 64'd1);
      S_WE   = 1'b1;
      S_DATA = 32'h5555_AAAA;
      push_exp(32'h5555_AAAA);
      @(posedge clk); #1;
      S_WE = 1'b0;
      check("coll_overflow", 64'(Overflow), 64'd0);
      for (int i = 1; i < 64; i++) wr(32'h5A00_0000 + 32'(i), 1'b1);
      drain("coll_drain");
      check("coll_overflow_total", 64'(ovf_seen - base_ovf), 64'd0);

      // Reset in the middle of a frame, then a fresh frame restarts at frame 0
      set_rdy(0);
      for (int i = 0; i < 74; i++) wr(32'h6000_0000 + 32'(i), 1'b1);
      set_rdy(1);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(T_VALID && T_USER[7:0] == 8'd30) && n < 300);
      check("rst_mid_beat30", 64'(T_USER[7:0]), 64'd30);
      reset = 1'b1;
      @(posedge clk); #1;
      check("rst_mid_valid", 64'(T_VALID), 64'd0);
      check("rst_mid_user", 64'(T_USER), 64'd0);
      q.delete();
      wcount     = 0;
      prev_stall = 1'b0;
      reset      = 1'b0;
      base_fs    = fs_seen;
      for (int i = 0; i < 64; i++) wr(32'h7000_0000 + 32'(i), 1'b1);
      drain("rst_fresh_drain");
      check("rst_fresh_frame_sent", 64'(fs_seen - base_fs), 64'd1);
      check("rst_idle_after", 64'(T_VALID), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, errors %0d of %0d checks", errors, checks);
      $fatal(1);
   end

endmodule

// File: doc/axis_frame_source.md
# axis_frame_source

AXI-Stream master that packs free-running 32-bit acquisition samples into 64-sample frames and streams them to the FFT/trigger path. Sits upstream of the trigger detector: it drives the `T_DATA`/`T_VALID`/`T_USER` stream that the detector consumes, and it honours `T_READY` backpressure. A ping-pong buffer decouples the unthrottled sample writer from the stalling stream reader.

## Interface
- `DATA_WIDTH`, 32, sample and stream data width
- `FRAME_LEN`, 64, samples per frame; power of two
- `ADDR_WIDTH`, 6, log2(`FRAME_LEN`)

- `clk`  in  1  sole clock; all logic rising-edge
- `reset`  in  1  one clock; reset is synchronous and active-high
- `S_DATA`  in  `DATA_WIDTH`  acquisition sample
- `S_WE`  in  1  sample write strobe, one sample per high cycle, no backpressure
- `T_DATA`  out  `DATA_WIDTH`  stream data
- `T_VALID`  out  1  stream valid
- `T_READY`  in  1  downstream ready
- `T_LAST`  out  1  high on last beat (index `FRAME_LEN`-1)
- `T_USER`  out  16  [7:0] beat index within frame, [15:8] frame counter
- `Overflow`  out  1  one-cycle pulse per dropped sample
- `Frame_Sent`  out  1  one-cycle pulse when a frame's last beat handshakes

## Operation
- Two banks (0/1) of `FRAME_LEN` words, each with a full flag. Reset: both flags clear, write bank = 0, write index = 0, frame counter = 0, read bank = 0.
- Write side: on `S_WE`, if the write bank is not full, store `S_DATA` at the write index and increment it. On the write to index `FRAME_LEN`-1: set that bank's full flag, wrap the index to 0, toggle the write bank.
- If the write bank is full, the sample is dropped, `Overflow` pulses, and the index holds.
- Read FSM states:
  - IDLE: if the read bank is full -> PRIME.
  - PRIME: RAM address = read bank/index 0 -> STREAM.
  - STREAM: `T_VALID`=1.
- On a STREAM handshake (`T_VALID && T_READY`):
  - index < `FRAME_LEN`-1: increment index.
  - index = `FRAME_LEN`-1: clear the read bank full flag, pulse `Frame_Sent`, increment the frame counter (mod 256), toggle the read bank, index = 0, then -> STREAM if the new read bank is already full, else IDLE. Continuing straight to STREAM is legal because the new bank's address 0 is already presented in this cycle.
- Read address is combinational: index+1 (or the next bank's 0) in a handshake cycle, else the current index. This gives full throughput with synchronous-read RAM; `T_DATA` is the RAM output.
- AXI rules: `T_VALID` never depends on `T_READY`. While `T_VALID`=1 without a handshake, `T_DATA`, `T_USER` and `T_LAST` stay stable.
- Simultaneous events:
  - Bank release and `S_WE` targeting that bank in the same cycle: the sample is accepted, no `Overflow`.
  - Write side filling bank X in the same cycle the reader releases bank Y: both actions happen.
- Reset mid-frame: partial write frame and any in-flight stream are discarded. `T_VALID` is low in the cycle after the reset edge.

## Timing
- Output reset values: `T_VALID`=0, `T_LAST`=0, `T_USER`=0, `Overflow`=0, `Frame_Sent`=0. `T_DATA` is don't-care while `T_VALID`=0.
- Latency: the write to index 63 at edge N sets the full flag; FSM is in PRIME after N+1; `T_VALID`=1 after N+2.
- Throughput: one beat per cycle while `T_READY`=1. Back-to-back full banks stream with no bubble between frames.
- `Overflow` and `Frame_Sent` are registered, asserted for exactly the cycle after the triggering edge.

## Structure
- Shared package: `FRAME_LEN`/`ADDR_WIDTH` constants, read FSM state enum (IDLE, PRIME, STREAM), `T_USER` field offsets.
- One sub-module `pingpong_ram`: simple dual-port, 2×`FRAME_LEN`×`DATA_WIDTH`, one write port, one synchronous read port, address = {bank, index}.
- FSM, flags and counters stay in the top module.

## Test plan
- Basic frame, `T_READY` tied 1: write samples 0..63 -> `T_VALID` rises 2 cycles after the 64th write; beats carry 0..63; `T_USER`=0x0000..0x003F; `T_LAST` only on beat 63; one `Frame_Sent`.
- Backpressure: `T_READY` toggles 1/0 pseudo-randomly -> no beat lost or duplicated; outputs stable during stalls; the second frame carries `T_USER`[15:8]=1.
- Back-to-back: write 128 samples continuously with `T_READY`=0 until both banks are full, then `T_READY`=1 -> 128 contiguous beats, no bubble at the frame boundary.
- Overflow: both banks full, `T_READY`=0, 5 further `S_WE` -> 5 `Overflow` pulses; after release the next stored sample lands at index 0.
- Release/write collision: `S_WE` in the same cycle as the beat-63 handshake of the blocking bank -> sample stored, `Overflow`=0.
- Reset mid-stream at beat 30 -> `T_VALID`=0 next cycle; frame counter and flags clear; a fresh 64-sample write streams as frame 0.
